palindrome_stream_chk: RTL and testbench

Sequential, parametrised palindrome checker for symbol streams. Accepts a packet of up to MAX_LEN symbols, each SYM_W bits wide, over a valid/ready input, buffers it, and then compares mirrored symbol pairs one pair per cycle. It returns a verdict, the packet length and an overflow flag over a valid/ready output. It is the streaming, variable-length, multi-bit-symbol generation of the fixed-width combinational palindrome check, for use on data paths where the word arrives serially.

---
 rtl/palindrome_stream_chk.sv | 176 +++++++++++++++++
 tb/tb_palindrome_stream_chk.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/palindrome_stream_chk.sv
// palindrome_stream_chk: buffers a packet of up to MAX_LEN symbols, then
// compares mirrored symbol pairs one pair per cycle and reports the verdict.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready/in_data/in_last
// input stream; out_valid/out_ready result handshake with out_is_pal,
// out_len (saturating at MAX_LEN) and out_ovf.
// Optional macro PAL_EARLY_EXIT_EN: leave CMP on the first mismatching pair.
module palindrome_stream_chk #(
    parameter  int SYM_W   = 1,
    parameter  int MAX_LEN = 16,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_is_pal,
    output logic [LW-1:0]    out_len,
    output logic             out_ovf
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef PAL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             pal_q, pal_d;
    logic [IW-1:0]    lo_q, lo_d;
    logic [IW-1:0]    hi_q, hi_d;
    logic [IW-1:0]    stop_q, stop_d;
    logic [SYM_W-1:0] buf_q [MAX_LEN];
    logic [SYM_W-1:0] buf_d [MAX_LEN];
    logic             out_valid_q, out_valid_d;
    logic             out_is_pal_q, out_is_pal_d;
    logic [LW-1:0]    out_len_q, out_len_d;
    logic             out_ovf_q, out_ovf_d;

    logic          beat;
    logic          full;
    logic          ovf_now;
    logic          mism;
    logic          cmp_end;
    logic [LW-1:0] len_now;
    logic [LW-1:0] pairs;

    assign in_ready   = (state_q == S_LOAD);
    assign out_valid  = out_valid_q;
    assign out_is_pal = out_is_pal_q;
    assign out_len    = out_len_q;
    assign out_ovf    = out_ovf_q;

    assign beat    = in_valid & in_ready;
    assign full    = (cnt_q == LW'(MAX_LEN));
    // The last beat itself may be the one that overflows.
    assign ovf_now = ovf_q | full;
    assign len_now = ovf_now ? LW'(MAX_LEN) : cnt_q + LW'(1);
    assign pairs   = len_now >> 1;
    assign mism    = (buf_q[lo_q] != buf_q[hi_q]);
    assign cmp_end = (lo_q == stop_q) | (EARLY & mism);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        ovf_d        = ovf_q;
        pal_d        = pal_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        stop_d       = stop_q;
        buf_d        = buf_q;
        out_valid_d  = out_valid_q;
        out_is_pal_d = out_is_pal_q;
        out_len_d    = out_len_q;
        out_ovf_d    = out_ovf_q;
        case (state_q)
            S_LOAD: begin
                if (beat) begin
                    if (!full) begin
                        buf_d[cnt_q[IW-1:0]] = in_data;
                        cnt_d = cnt_q + LW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = S_CMP;
                        len_d   = len_now;
                        lo_d    = '0;
                        // No pair to compare (L=1) or overflow: spend one
                        // self-compare cycle so latency is max(P,1).
                        if (ovf_now || pairs == '0) begin
                            hi_d   = '0;
                            stop_d = '0;
                            pal_d  = ~ovf_now;
                        end else begin
                            hi_d   = IW'(len_now - LW'(1));
                            stop_d = IW'(pairs - LW'(1));
                            pal_d  = 1'b1;
                        end
                    end
                end
            end
            S_CMP: begin
                pal_d = pal_q & ~mism;
                lo_d  = lo_q + IW'(1);
                hi_d  = hi_q - IW'(1);
                if (cmp_end) begin
                    state_d      = S_DONE;
                    out_valid_d  = 1'b1;
                    out_is_pal_d = pal_q & ~mism;
                    out_len_d    = len_q;
                    out_ovf_d    = ovf_q;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_LOAD;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    pal_d       = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_LOAD;
            cnt_q        <= '0;
            len_q        <= '0;
            ovf_q        <= 1'b0;
            pal_q        <= 1'b1;
            lo_q         <= '0;
            hi_q         <= '0;
            stop_q       <= '0;
            out_valid_q  <= 1'b0;
            out_is_pal_q <= 1'b0;
            out_len_q    <= '0;
            out_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            ovf_q        <= ovf_d;
            pal_q        <= pal_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            stop_q       <= stop_d;
            out_valid_q  <= out_valid_d;
            out_is_pal_q <= out_is_pal_d;
            out_len_q    <= out_len_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

    // Symbol storage needs no reset: only written slots are ever read.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_palindrome_stream_chk.sv
// tb_palindrome_stream_chk: directed packets with hand-computed verdict,
// length, overflow and latency for palindrome_stream_chk (SYM_W=8).
module tb_palindrome_stream_chk;

    localparam int SYM_W   = 8;
    localparam int MAX_LEN = 16;
    localparam int LW      = $clog2(MAX_LEN + 1);

`ifdef PAL_EARLY_EXIT_EN
    localparam int LAT_BITS_BAD = 1;
`else
    localparam int LAT_BITS_BAD = 7;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [SYM_W-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_is_pal;
    logic [LW-1:0]    out_len;
    logic             out_ovf;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] pkt [$];

    palindrome_stream_chk #(
        .SYM_W   (SYM_W),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_is_pal (out_is_pal),
        .out_len    (out_len),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_bits(input logic [31:0] v, input int n);
        pkt.delete();
        for (int i = 0; i < n; i++)
            pkt.push_back({7'b0, v[n-1-i]});
    endtask

    // Drives pkt; returns at E0 + 1 time unit.
    task automatic send(input string tag);
        int rdy;
        rdy = 0;
        for (int i = 0; i < pkt.size(); i++) begin
            in_valid = 1'b1;
            in_data  = pkt[i];
            in_last  = (i == pkt.size() - 1);
            if (in_ready) rdy++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, ".rdy"}, rdy, pkt.size());
    endtask

    task automatic finish_pkt(input string tag, input int e_pal,
                              input int e_len, input int e_ovf,
                              input int e_lat, input int hold);
        int lat;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"}, lat, e_lat);
        check({tag, ".pal"}, out_is_pal, e_pal);
        check({tag, ".len"}, out_len, e_len);
        check({tag, ".ovf"}, out_ovf, e_ovf);
        check({tag, ".busy"}, in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, ".hv"}, out_valid, 1);
            check({tag, ".hpal"}, out_is_pal, e_pal);
            check({tag, ".hlen"}, out_len, e_len);
            check({tag, ".hrdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".vdrop"}, out_valid, 0);
        check({tag, ".rdy1"}, in_ready, 1);
    endtask

    task automatic run_pkt(input string tag, input int e_pal,
                           input int e_len, input int e_ovf,
                           input int e_lat, input int hold);
        send(tag);
        finish_pkt(tag, e_pal, e_len, e_ovf, e_lat, hold);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst.valid", out_valid, 0);
        check("rst.ready", in_ready, 1);
        check("rst.pal", out_is_pal, 0);
        check("rst.len", out_len, 0);
        check("rst.ovf", out_ovf, 0);

        load_bits(32'b111100010001111, 15);
        run_pkt("bits_pal", 1, 15, 0, 7, 0);

        load_bits(32'b110011001100110, 15);
        run_pkt("bits_bad", 0, 15, 0, LAT_BITS_BAD, 0);

        pkt = '{8'h52, 8'h41, 8'h43, 8'h45, 8'h43, 8'h41, 8'h52};
        run_pkt("racecar", 1, 7, 0, 3, 5);

        // mismatch lands on pair 2, so early exit still needs 3 edges
        pkt = '{8'h52, 8'h41, 8'h43, 8'h45, 8'h44, 8'h41, 8'h52};
        run_pkt("racebar", 0, 7, 0, 3, 0);

        pkt = '{8'h3C};
        run_pkt("single", 1, 1, 0, 1, 0);

        pkt = '{8'hA5, 8'hA5};
        run_pkt("pair_eq", 1, 2, 0, 1, 0);

        pkt = '{8'hA5, 8'h5A};
        run_pkt("pair_ne", 0, 2, 0, 1, 0);

        pkt.delete();
        for (int i = 0; i < 8; i++) pkt.push_back(8'(i * 17));
        for (int i = 7; i >= 0; i--) pkt.push_back(8'(i * 17));
        run_pkt("full16", 1, 16, 0, 8, 0);

        pkt.delete();
        for (int i = 0; i < 20; i++) pkt.push_back(8'h77);
        run_pkt("ovf20", 0, 16, 1, 1, 0);

        pkt = '{8'hA5, 8'hA5};
        run_pkt("post_ovf", 1, 2, 0, 1, 0);

        load_bits(32'b111100010001111, 15);
        send("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst.valid", out_valid, 0);
        check("mid_rst.ready", in_ready, 1);

        pkt = '{8'h52, 8'h41, 8'h43, 8'h45, 8'h43, 8'h41, 8'h52};
        run_pkt("fresh", 1, 7, 0, 3, 0);

        pkt = '{8'h01, 8'h02, 8'h03};
        run_pkt("odd3_ne", 0, 3, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
